// File: rtl/lvds_rx_word_align.sv
// Word aligner for the LVDS receive path: sweeps a 0..7 bit rotation over a
// two-word window until the training word is seen LOCK_CNT times in a row.
module lvds_rx_word_align #(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'h0F,
  parameter int                LOCK_CNT      = 4,
  parameter int                SWEEP_MAX     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              realign,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              aligned,
  output logic [2:0]        offset,
  output logic              align_err
);

  localparam int SW_W = $clog2(SWEEP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_aligned;
  logic [2:0]        r_offset;
  logic              r_align_err;
  logic              r_settle;
  logic [3:0]        r_match_cnt;
  logic [SW_W-1:0]   r_sweep_cnt;

  logic [DATA_W-1:0] w_cand;
  logic              w_match;
  logic              w_wrap;
  logic [2:0]        w_offset_inc;

  // Selects window[15-off -: 8]; off=0 yields the older word unchanged.
  function automatic logic [DATA_W-1:0] f_rotate(input logic [DATA_W-1:0] prev,
                                                 input logic [DATA_W-1:0] cur,
                                                 input logic [2:0]        off);
    logic [2*DATA_W-1:0] sh;
    sh = {prev, cur} << off;
    return sh[2*DATA_W-1 -: DATA_W];
  endfunction

  assign w_cand       = f_rotate(r_prev, rx_data, r_offset);
  assign w_match      = (r_data_out == TRAIN_PATTERN);
  assign w_wrap       = (r_offset == 3'd7);
  assign w_offset_inc = r_offset + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= '0;
      r_data_out <= '0;
    end else if (rx_valid) begin
      r_prev     <= rx_data;
      r_data_out <= w_cand;
    end
  end

  // data_out lags an offset change by one clock, so each new offset gets a
  // settle cycle before its candidate is compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_data_valid <= 1'b0;
      r_aligned    <= 1'b0;
      r_offset     <= 3'd0;
      r_align_err  <= 1'b0;
      r_settle     <= 1'b0;
      r_match_cnt  <= 4'd0;
      r_sweep_cnt  <= '0;
    end else if (realign) begin
      r_aligned    <= 1'b0;
      r_data_valid <= 1'b0;
      r_align_err  <= 1'b0;
      r_sweep_cnt  <= '0;
      r_match_cnt  <= 4'd0;
      r_offset     <= 3'd0;
      r_settle     <= 1'b1;
      r_state      <= rx_valid ? SEARCH : IDLE;
    end else if (!rx_valid && (r_state != IDLE)) begin
      r_state      <= IDLE;
      r_aligned    <= 1'b0;
      r_data_valid <= 1'b0;
      r_match_cnt  <= 4'd0;
      r_sweep_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_aligned    <= 1'b0;
          r_data_valid <= 1'b0;
          if (rx_valid) begin
            r_offset <= 3'd0;
            r_settle <= 1'b1;
            r_state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (r_settle) begin
            r_settle <= 1'b0;
          end else if (w_match) begin
            r_match_cnt <= 4'd1;
            if (LOCK_CNT == 1) begin
              r_state      <= LOCKED;
              r_aligned    <= 1'b1;
              r_data_valid <= 1'b1;
            end else begin
              r_state <= VERIFY;
            end
          end else begin
            r_offset <= w_offset_inc;
            r_settle <= 1'b1;
            if (w_wrap) begin
              if (r_sweep_cnt == SW_W'(SWEEP_MAX - 1)) begin
                r_align_err <= 1'b1;
                r_sweep_cnt <= '0;
              end else begin
                r_sweep_cnt <= r_sweep_cnt + SW_W'(1);
              end
            end
          end
        end
        VERIFY: begin
          if (w_match) begin
            r_match_cnt <= r_match_cnt + 4'd1;
            if (r_match_cnt == 4'(LOCK_CNT - 1)) begin
              r_state      <= LOCKED;
              r_aligned    <= 1'b1;
              r_data_valid <= 1'b1;
            end
          end else begin
            r_match_cnt <= 4'd0;
            r_offset    <= w_offset_inc;
            r_settle    <= 1'b1;
            r_state     <= SEARCH;
          end
        end
        LOCKED: begin
          r_aligned    <= 1'b1;
          r_data_valid <= rx_valid;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign aligned    = r_aligned;
  assign offset     = r_offset;
  assign align_err  = r_align_err;

endmodule

// File: doc/lvds_rx_word_align.md
Name: lvds_rx_word_align

Overview:
- Receive-side word aligner for the LVDS link. Sits on the slow-clock side, directly after the LVDS deserializer's 8-bit parallel output.
- Recovers byte boundaries from a repeated training pattern by sweeping a 0..7 bit rotation over a two-word window.
- Locks after consecutive matches, then delivers aligned payload bytes with a valid strobe.
- Reports lock status, the chosen offset, and a sticky alignment-failure flag.

Parameters:
- DATA_W, 8: parallel word width. Only 8 is supported.
- TRAIN_PATTERN, 8'h0F: training word. All 8 rotations of it must be distinct.
- LOCK_CNT, 4: consecutive pattern matches required to declare lock, range 1..15.
- SWEEP_MAX, 4: full 8-offset sweeps without lock before align_err is raised.

Ports:
- clk, input, 1: LVDS slow (parallel) clock.
- rst, input, 1: asynchronous reset, active-high.
- rx_data, input, 8: deserializer parallel output. Bit 7 is the oldest received bit.
- rx_valid, input, 1: PLL locked / deserializer output valid. Level signal.
- realign, input, 1: one-cycle pulse that forces a new alignment search.
- data_out, output, 8: aligned byte.
- data_valid, output, 1: data_out holds payload. Asserted only while aligned.
- aligned, output, 1: lock achieved.
- offset, output, 3: current rotation offset.
- align_err, output, 1: sticky flag, SWEEP_MAX sweeps elapsed without lock.

Behaviour:
- Reset values: data_out=0, data_valid=0, aligned=0, offset=0, align_err=0, state=IDLE, all counters 0.
- Datapath:
  - prev <= rx_data on every clk with rx_valid=1.
  - window[15:0] = {prev, rx_data}.
  - cand = window[15-offset -: 8], so offset=0 selects prev.
  - data_out <= cand every cycle with rx_valid=1; otherwise data_out holds.
  - Latency from rx_data to data_out is one clk.
- Match: match = (data_out == TRAIN_PATTERN), evaluated only on cycles not marked settle.
- States:
  - IDLE:
    - aligned=0, data_valid=0.
    - When rx_valid=1: offset<=0, go to SEARCH with settle=1.
  - SEARCH:
    - A settle cycle only clears settle; no compare.
    - Otherwise, on match: match_cnt<=1. If LOCK_CNT==1 go to LOCKED, else go to VERIFY.
    - Otherwise, on mismatch: offset<=offset+1 (wraps 7->0) and settle<=1.
    - On each 7->0 wrap, sweep_cnt++. When sweep_cnt reaches SWEEP_MAX, align_err<=1 and sweep_cnt<=0. Search continues.
  - VERIFY:
    - On match: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED.
    - On mismatch: match_cnt<=0, offset<=offset+1, settle<=1, go to SEARCH.
  - LOCKED:
    - aligned=1, offset frozen.
    - data_valid=1 on every cycle where data_out was updated, i.e. the previous cycle had rx_valid=1.
    - Payload is not checked against the pattern.
- Realign and loss of valid:
  - realign=1 in any state: aligned<=0, data_valid<=0, align_err<=0, sweep_cnt<=0, match_cnt<=0, offset<=0, settle<=1.
  - After realign, go to SEARCH if rx_valid=1, else go to IDLE.
  - rx_valid=0 in SEARCH, VERIFY or LOCKED: go to IDLE next clk. aligned, data_valid, match_cnt and sweep_cnt clear. align_err is held.
  - Simultaneous realign and rx_valid falling: realign clears state, and the block goes to IDLE.
- Timing bound: each rejected offset costs 2 clk (settle + compare). Lock at offset k is reached at most 2k+LOCK_CNT+3 clk after rx_valid rises.
- Async rst mid-operation returns everything to reset values immediately.

Test Plan:
- Aligned stream: rx_valid=1, rx_data=8'h0F continuous -> offset=0; aligned=1 within 8 clk; data_out=8'h0F; data_valid=1 from that cycle.
- Shifted stream: rx_data=8'h78 continuous -> offset sweeps 0..5 and holds at 5; aligned=1 within 18 clk; data_out=8'h0F.
- Payload after lock: stream 8'h78 to lock, then bytes 8'h08,8'h88,8'h91,8'h22 -> data_out = {prev,cur} rotated by 5, i.e. 8'h01,8'h11,8'h12,8'h24 with the word boundary per the window rule; aligned stays 1.
- Broken verify: 8'h0F twice, then 8'h00 before LOCK_CNT matches -> back to SEARCH, offset=1, aligned=0. A later 8'h0F stream locks at offset 0 after wrap.
- No pattern: rx_data=8'h00 for 80 clk -> aligned=0; align_err=1 after 4 sweeps (64 clk); realign pulse clears align_err.
- Disturbances: drop rx_valid while LOCKED -> aligned=0 and data_valid=0 next clk, state IDLE; re-raise with 8'h78 -> relock at offset 5. Assert rst mid-VERIFY -> all outputs 0 immediately.
